// File: rtl/hsid_best_match_if.sv
// Handshake and result bus between the search controller / divider and hsid_best_match.
// The master side drives search control and divider results; the slave side reports the best match.
interface hsid_best_match_if #(
  parameter int unsigned HSP_LIBRARY_WIDTH = 8,
  parameter int unsigned K                 = 32
);
  logic                         clear;
  logic                         start;
  logic [HSP_LIBRARY_WIDTH-1:0] library_size;
  logic                         div_done;
  logic [K-1:0]                 div_quotient;
  logic                         div_overflow;
  logic [HSP_LIBRARY_WIDTH-1:0] div_hsp_ref;

  logic                         idle;
  logic                         ready;
  logic                         done;
  logic                         best_valid;
  logic [K-1:0]                 best_value;
  logic [HSP_LIBRARY_WIDTH-1:0] best_ref;
  logic [HSP_LIBRARY_WIDTH-1:0] result_count;
  logic [HSP_LIBRARY_WIDTH-1:0] overflow_count;

  modport master (
    output clear, start, library_size, div_done, div_quotient, div_overflow, div_hsp_ref,
    input  idle, ready, done, best_valid, best_value, best_ref, result_count, overflow_count
  );

  modport slave (
    input  clear, start, library_size, div_done, div_quotient, div_overflow, div_hsp_ref,
    output idle, ready, done, best_valid, best_value, best_ref, result_count, overflow_count
  );
endinterface

// File: rtl/hsid_best_match.sv
// Tracks the minimum non-overflowed divider quotient over one library search and
// pulses done once the configured number of results has been collected.
module hsid_best_match #(
  parameter int unsigned HSP_LIBRARY_WIDTH = 8,
  parameter int unsigned K                 = 32
) (
  input  logic             clk,
  input  logic             rst,
  hsid_best_match_if.slave bus
);

  localparam int unsigned HW = HSP_LIBRARY_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  size_q, size_d;
  logic           best_valid_q, best_valid_d;
  logic [K-1:0]   best_value_q, best_value_d;
  logic [HW-1:0]  best_ref_q, best_ref_d;
  logic [HW-1:0]  result_count_q, result_count_d;
  logic [HW-1:0]  overflow_count_q, overflow_count_d;
  logic [HW-1:0]  result_count_inc;

  assign result_count_inc = HW'(result_count_q + HW'(1));

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      size_q           <= '0;
      best_valid_q     <= 1'b0;
      best_value_q     <= '1;
      best_ref_q       <= '0;
      result_count_q   <= '0;
      overflow_count_q <= '0;
    end else begin
      state_q          <= state_d;
      size_q           <= size_d;
      best_valid_q     <= best_valid_d;
      best_value_q     <= best_value_d;
      best_ref_q       <= best_ref_d;
      result_count_q   <= result_count_d;
      overflow_count_q <= overflow_count_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d          = state_q;
    size_d           = size_q;
    best_valid_d     = best_valid_q;
    best_value_d     = best_value_q;
    best_ref_d       = best_ref_q;
    result_count_d   = result_count_q;
    overflow_count_d = overflow_count_q;

    if (bus.clear) begin
      // Abort wins over everything, including a coincident divider result
      state_d          = IDLE;
      size_d           = '0;
      best_valid_d     = 1'b0;
      best_value_d     = '1;
      best_ref_d       = '0;
      result_count_d   = '0;
      overflow_count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            size_d           = bus.library_size;
            best_valid_d     = 1'b0;
            best_value_d     = '1;
            best_ref_d       = '0;
            result_count_d   = '0;
            overflow_count_d = '0;
            state_d          = (bus.library_size == '0) ? DONE : TRACK;
          end
        end
        TRACK: begin
          if (bus.div_done) begin
            result_count_d = result_count_inc;
            if (bus.div_overflow) begin
              overflow_count_d = HW'(overflow_count_q + HW'(1));
            end else if (!best_valid_q || (bus.div_quotient < best_value_q)) begin
              best_valid_d = 1'b1;
              best_value_d = bus.div_quotient;
              best_ref_d   = bus.div_hsp_ref;
            end
            if (result_count_inc == size_q) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.idle           = (state_q == IDLE);
  assign bus.ready          = (state_q == IDLE);
  assign bus.done           = (state_q == DONE);
  assign bus.best_valid     = best_valid_q;
  assign bus.best_value     = best_value_q;
  assign bus.best_ref       = best_ref_q;
  assign bus.result_count   = result_count_q;
  assign bus.overflow_count = overflow_count_q;

endmodule

// File: tb/tb_hsid_best_match.sv
// Directed self-checking bench for hsid_best_match.
module tb_hsid_best_match;

  localparam int unsigned LW = 8;
  localparam int unsigned KW = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hsid_best_match_if #(.HSP_LIBRARY_WIDTH(LW), .K(KW)) bus ();

  hsid_best_match #(.HSP_LIBRARY_WIDTH(LW), .K(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start_search(input logic [LW-1:0] size);
    bus.start        = 1'b1;
    bus.library_size = size;
    step();
    bus.start        = 1'b0;
    bus.library_size = '0;
  endtask

  task automatic send(input logic [KW-1:0] q, input logic [LW-1:0] r, input logic ovf);
    bus.div_done     = 1'b1;
    bus.div_quotient = q;
    bus.div_hsp_ref  = r;
    bus.div_overflow = ovf;
    step();
    bus.div_done     = 1'b0;
    bus.div_quotient = '0;
    bus.div_hsp_ref  = '0;
    bus.div_overflow = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1; bus.clear = 1'b0; bus.div_done = 1'b1;
    bus.library_size = 8'd3; bus.div_quotient = 32'd4; bus.div_hsp_ref = 8'd2;
    step();
    bus.clear = 1'b1; bus.div_overflow = 1'b1; bus.div_quotient = 32'd1;
    step();
    chk("rst_idle",       32'(bus.idle),           32'd1);
    chk("rst_ready",      32'(bus.ready),          32'd1);
    chk("rst_done",       32'(bus.done),           32'd0);
    chk("rst_best_value", bus.best_value,          32'hFFFFFFFF);
    chk("rst_best_valid", 32'(bus.best_valid),     32'd0);
    chk("rst_best_ref",   32'(bus.best_ref),       32'd0);
    chk("rst_res_cnt",    32'(bus.result_count),   32'd0);
    chk("rst_ovf_cnt",    32'(bus.overflow_count), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.div_done = 1'b0; bus.div_overflow = 1'b0;
    bus.library_size = '0; bus.div_quotient = '0; bus.div_hsp_ref = '0;
    step();
    chk("post_rst_idle", 32'(bus.idle), 32'd1);
  endtask

  task automatic test_min_with_tie;
    start_search(8'd4);
    chk("min_track_idle", 32'(bus.idle), 32'd0);
    send(32'd50, 8'd0, 1'b0);
    send(32'd20, 8'd1, 1'b0);
    send(32'd20, 8'd2, 1'b0);
    chk("min_no_early_done", 32'(bus.done), 32'd0);
    chk("min_mid_count", 32'(bus.result_count), 32'd3);
    send(32'd70, 8'd3, 1'b0);
    chk("min_done",       32'(bus.done),           32'd1);
    chk("min_best_value", bus.best_value,          32'd20);
    chk("min_best_ref",   32'(bus.best_ref),       32'd1);
    chk("min_best_valid", 32'(bus.best_valid),     32'd1);
    chk("min_res_cnt",    32'(bus.result_count),   32'd4);
    chk("min_ovf_cnt",    32'(bus.overflow_count), 32'd0);
    step();
    chk("min_done_pulse", 32'(bus.done), 32'd0);
    chk("min_back_idle",  32'(bus.idle), 32'd1);
    chk("min_hold_value", bus.best_value, 32'd20);
  endtask

  task automatic test_overflow;
    start_search(8'd3);
    send(32'd5, 8'd0, 1'b1);
    send(32'd9, 8'd1, 1'b0);
    send(32'd3, 8'd2, 1'b1);
    chk("ovf_done",       32'(bus.done),           32'd1);
    chk("ovf_best_value", bus.best_value,          32'd9);
    chk("ovf_best_ref",   32'(bus.best_ref),       32'd1);
    chk("ovf_best_valid", 32'(bus.best_valid),     32'd1);
    chk("ovf_ovf_cnt",    32'(bus.overflow_count), 32'd2);
    chk("ovf_res_cnt",    32'(bus.result_count),   32'd3);
    step();
  endtask

  task automatic test_all_overflow;
    start_search(8'd2);
    send(32'd1, 8'd4, 1'b1);
    send(32'd2, 8'd5, 1'b1);
    chk("allovf_done",       32'(bus.done),           32'd1);
    chk("allovf_best_valid", 32'(bus.best_valid),     32'd0);
    chk("allovf_best_value", bus.best_value,          32'hFFFFFFFF);
    chk("allovf_ovf_cnt",    32'(bus.overflow_count), 32'd2);
    step();
  endtask

  task automatic test_clear;
    start_search(8'd3);
    send(32'd11, 8'd6, 1'b0);
    bus.clear = 1'b1;
    bus.div_done = 1'b1; bus.div_quotient = 32'd1; bus.div_hsp_ref = 8'd9;
    step();
    bus.clear = 1'b0; bus.div_done = 1'b0; bus.div_quotient = '0; bus.div_hsp_ref = '0;
    chk("clr_idle",       32'(bus.idle),         32'd1);
    chk("clr_done",       32'(bus.done),         32'd0);
    chk("clr_res_cnt",    32'(bus.result_count), 32'd0);
    chk("clr_best_valid", 32'(bus.best_valid),   32'd0);
    chk("clr_best_value", bus.best_value,        32'hFFFFFFFF);
    step();
    chk("clr_no_done_later", 32'(bus.done), 32'd0);
    start_search(8'd1);
    send(32'd7, 8'd5, 1'b0);
    chk("clr_restart_done",  32'(bus.done),     32'd1);
    chk("clr_restart_ref",   32'(bus.best_ref), 32'd5);
    chk("clr_restart_value", bus.best_value,    32'd7);
    step();
  endtask

  task automatic test_zero_size;
    start_search(8'd0);
    chk("zero_done",       32'(bus.done),         32'd1);
    chk("zero_best_valid", 32'(bus.best_valid),   32'd0);
    chk("zero_res_cnt",    32'(bus.result_count), 32'd0);
    step();
    chk("zero_back_idle", 32'(bus.idle), 32'd1);
  endtask

  task automatic test_ignored_inputs;
    send(32'd1, 8'd7, 1'b0);
    chk("idle_divdone_value", bus.best_value,        32'hFFFFFFFF);
    chk("idle_divdone_cnt",   32'(bus.result_count), 32'd0);
    chk("idle_divdone_state", 32'(bus.idle),         32'd1);
    start_search(8'd2);
    bus.start = 1'b1; bus.library_size = 8'd1;
    send(32'd10, 8'd3, 1'b0);
    step();
    bus.start = 1'b0; bus.library_size = '0;
    chk("track_start_no_done", 32'(bus.done),         32'd0);
    chk("track_start_cnt",     32'(bus.result_count), 32'd1);
    send(32'd10, 8'd4, 1'b0);
    chk("tie_done", 32'(bus.done),     32'd1);
    chk("tie_ref",  32'(bus.best_ref), 32'd3);
    send(32'd0, 8'd8, 1'b0);
    chk("donestate_divdone_value", bus.best_value,        32'd10);
    chk("donestate_divdone_cnt",   32'(bus.result_count), 32'd2);
    chk("donestate_to_idle",       32'(bus.idle),         32'd1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("idle_clear_valid", 32'(bus.best_valid),   32'd0);
    chk("idle_clear_ref",   32'(bus.best_ref),     32'd0);
    chk("idle_clear_cnt",   32'(bus.result_count), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.clear = 1'b0; bus.start = 1'b0; bus.library_size = '0;
    bus.div_done = 1'b0; bus.div_quotient = '0; bus.div_overflow = 1'b0; bus.div_hsp_ref = '0;
    test_reset();
    test_min_with_tie();
    test_overflow();
    test_all_overflow();
    test_clear();
    test_zero_size();
    test_ignored_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
